// File: rtl/id_issue_queue_pkg.sv
// Shared types and constants for the decoded-instruction issue queue.
package id_issue_queue_pkg;

  localparam int unsigned FU_COUNT = 3;
  localparam int unsigned FU_MUL   = 0;
  localparam int unsigned FU_DIV   = 1;
  localparam int unsigned FU_FPU   = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] im;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [31:0] ctrl;
  } id_bundle_t;

  localparam int unsigned ID_BUNDLE_W = $bits(id_bundle_t);

endpackage

// File: rtl/iq_fu_tracker.sv
// Per-functional-unit pending bits for the queue head; each bit clears on its own handshake.
module iq_fu_tracker
  import id_issue_queue_pkg::*;
#(
  parameter int unsigned NUM_FU = FU_COUNT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_in,
  input  logic              head_valid,
  input  logic              load_en,
  input  logic [NUM_FU-1:0] load_sel,
  input  logic              clear_all,
  input  logic [NUM_FU-1:0] ready_in_fu,
  output logic [NUM_FU-1:0] valid_out_fu
);

  logic [NUM_FU-1:0] fu_pend_q, fu_pend_d;

  assign valid_out_fu = head_valid ? fu_pend_q : '0;

  // A head change overrides any handshake clear in the same cycle.
  always_comb begin
    fu_pend_d = fu_pend_q & ~(valid_out_fu & ready_in_fu);
    if (clear_all) fu_pend_d = '0;
    if (load_en)   fu_pend_d = load_sel;
    if (flush_in)  fu_pend_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fu_pend_q <= '0;
    else        fu_pend_q <= fu_pend_d;
  end

endmodule

// File: rtl/id_issue_queue.sv
// DEPTH-entry decoded-instruction queue between decoder and EX.
// Define IQ_FULL_PUSH_EN to let a full queue accept a push in the same cycle as a pop.
module id_issue_queue
  import id_issue_queue_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = ID_BUNDLE_W,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_FU    = FU_COUNT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  output logic                         ready_out,
  input  logic                         flush_in,
  output logic                         flush_out,
  input  logic [PAYLOAD_W-1:0]         payload_in,
  input  logic [NUM_FU-1:0]            fu_sel_in,
  input  logic                         serialize_in,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic [PAYLOAD_W-1:0]         payload_out,
  output logic                         serialize_out,
  output logic [NUM_FU-1:0]            valid_out_fu,
  input  logic [NUM_FU-1:0]            ready_in_fu,
  output logic [$clog2(DEPTH+1)-1:0]   count_out
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PAYLOAD_W-1:0] mem_q     [DEPTH];
  logic [PAYLOAD_W-1:0] mem_d     [DEPTH];
  logic                 ser_mem_q [DEPTH];
  logic                 ser_mem_d [DEPTH];
  logic [NUM_FU-1:0]    fu_mem_q  [DEPTH];
  logic [NUM_FU-1:0]    fu_mem_d  [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d, ser_cnt_q, ser_cnt_d;

  logic              empty, push, pop;
  logic              fu_load, fu_clear_all;
  logic [NUM_FU-1:0] fu_load_sel;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty         = (count_q == '0);
  assign valid_out     = !empty;
  assign payload_out   = empty ? '0 : mem_q[rptr_q];
  assign serialize_out = !empty && ser_mem_q[rptr_q];
  assign count_out     = count_q;
  assign flush_out     = flush_in;

  assign pop = valid_out && ready_in && !flush_in;

`ifdef IQ_FULL_PUSH_EN
  assign ready_out = !flush_in && (ser_cnt_q == '0) && ((count_q < CNT_W'(DEPTH)) || pop);
`else
  assign ready_out = !flush_in && (ser_cnt_q == '0) && (count_q < CNT_W'(DEPTH));
`endif

  assign push = valid_in && ready_out;

  // Head changes on push-into-empty, on pop exposing the next entry, or on pop+push when one entry is held.
  always_comb begin
    fu_load      = (push && empty) || (pop && (count_q > CNT_W'(1))) ||
                   (pop && push && (count_q == CNT_W'(1)));
    fu_load_sel  = (pop && (count_q > CNT_W'(1))) ? fu_mem_q[ptr_inc(rptr_q)] : fu_sel_in;
    fu_clear_all = pop && !push && (count_q == CNT_W'(1));
  end

  always_comb begin
    mem_d     = mem_q;
    ser_mem_d = ser_mem_q;
    fu_mem_d  = fu_mem_q;
    if (push) begin
      mem_d[wptr_q]     = payload_in;
      ser_mem_d[wptr_q] = serialize_in;
      fu_mem_d[wptr_q]  = fu_sel_in;
    end
  end

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    ser_cnt_d = ser_cnt_q;
    if (flush_in) begin
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      ser_cnt_d = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      ser_cnt_d = ser_cnt_q + CNT_W'(push && serialize_in) - CNT_W'(pop && serialize_out);
    end
  end

  // Entry storage carries no reset; empty-queue outputs are masked instead.
  always_ff @(posedge clk) begin
    mem_q     <= mem_d;
    ser_mem_q <= ser_mem_d;
    fu_mem_q  <= fu_mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ser_cnt_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ser_cnt_q <= ser_cnt_d;
    end
  end

  iq_fu_tracker #(.NUM_FU(NUM_FU)) u_fu_tracker (
    .clk          (clk),
    .reset        (reset),
    .flush_in     (flush_in),
    .head_valid   (valid_out),
    .load_en      (fu_load),
    .load_sel     (fu_load_sel),
    .clear_all    (fu_clear_all),
    .ready_in_fu  (ready_in_fu),
    .valid_out_fu (valid_out_fu)
  );

endmodule

// File: doc/id_issue_queue.md
Name: id_issue_queue

Overview:
- Parametrised successor to the single-entry ID/EX register: a DEPTH-entry decoded-instruction queue between the decoder and EX.
- Holds the packed decode bundle and presents the head entry to EX with a valid/ready handshake.
- Per functional unit, raises an independent valid that clears on that unit's handshake.
- Stalls intake while a serialising entry (CSR access or pending exception) is in flight.

Parameters:
PAYLOAD_W, 256, width of packed decode bundle (PC, IR, IM, operands, control fields)
DEPTH, 4, queue entries (>=1, any integer; not required to be a power of 2)
NUM_FU, 3, number of side-channel functional units (mul, div, fpu)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
valid_in  in  1  decoder has a bundle
ready_out  out  1  queue accepts bundle this cycle
flush_in  in  1  synchronous flush from downstream
flush_out  out  1  equal to flush_in, combinational
payload_in  in  PAYLOAD_W  decode bundle
fu_sel_in  in  NUM_FU  one-hot/zero FU selector of incoming bundle
serialize_in  in  1  bundle is CSR read/write or exc_pend
valid_out  out  1  head entry valid toward EX
ready_in  in  1  EX accepts head
payload_out  out  PAYLOAD_W  head bundle
serialize_out  out  1  head serialise flag
valid_out_fu  out  NUM_FU  per-FU valid for head
ready_in_fu  in  NUM_FU  per-FU ready
count_out  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (reset=0, async): wptr=rptr=0, count=0, ser_cnt=0, fu_pend=0.
  - Reset outputs: valid_out=0, valid_out_fu=0, count_out=0, payload_out=0, serialize_out=0.
- push = valid_in && ready_out; pop = valid_out && ready_in.
- ready_out = !flush_in && (ser_cnt==0) && (count<DEPTH).
- Latency: bundle pushed at edge n is visible at head (valid_out=1) after edge n, provided the queue was empty. No combinational in->out path.
- Storage is registered. payload_out/serialize_out read the entry at rptr; when the queue is empty they are 0.
- Pointers advance by 1 and wrap from DEPTH-1 to 0.
- count update: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- ser_cnt tracks serialising entries in the queue:
  - +1 on push with serialize_in, -1 on pop with serialize_out.
  - Intake stays blocked until the serialising entry has popped.
- Per-FU valid:
  - fu_pend loads the new head's fu_sel whenever the head changes: push into empty queue, or pop with count>1.
  - After a pop that leaves the queue empty, fu_pend clears.
  - valid_out_fu = fu_pend when valid_out=1, else 0.
  - Bit k clears on the edge where valid_out_fu[k] && ready_in_fu[k]; other bits are unaffected.
  - The head-change load takes priority over any clear in the same cycle.
- Main pop does not wait for FU handshakes. EX guarantees ordering; any FU bit still set on pop is discarded.
- flush_in=1: on the next edge, pointers, count, ser_cnt and fu_pend are cleared.
  - No push in that cycle (ready_out=0).
  - pop in the flush cycle is ignored.
  - Flush has priority over everything except reset.
- Reset asserted mid-operation clears state immediately, including any partially completed FU handshakes.
- Empty: valid_out=0 and ready_in is ignored. Full: ready_out=0, except as described under Optional Feature.

Optional Feature:
- Macro: IQ_FULL_PUSH_EN.
- Defined: ready_out = !flush_in && (ser_cnt==0) && (count<DEPTH || pop).
  - A full queue accepts a push in the same cycle as a pop; count stays DEPTH.
  - This introduces a combinational ready_in->ready_out path.
- Undefined: ready_out is as specified under Behaviour. A full queue never accepts; no ready_in->ready_out path.

Decomposition:
- CPU_pkg gains the following; NUM_FU defaults from FU_COUNT:
  - FU_COUNT=3.
  - FU index constants FU_MUL=0, FU_DIV=1, FU_FPU=2.
  - A packed struct typedef id_bundle_t whose $bits equals PAYLOAD_W.
- One natural sub-module: iq_fu_tracker, holding the fu_pend register, head-change load and per-bit clear logic.
- Storage and pointers stay in the top module.

Test Plan:
- DEPTH=4, ready_in=0, push 4 bundles (payload 0x1..0x4):
  - count_out=4, ready_out=0.
  - Then ready_in=1 pops 0x1,0x2,0x3,0x4 on consecutive cycles, and count_out returns to 0.
- Continuous push+pop, 10 bundles, DEPTH=3:
  - Order preserved across wrap-around and count_out stays 1.
  - With IQ_FULL_PUSH_EN and the queue full, simultaneous push+pop keeps count_out=3.
- Push a bundle with serialize_in=1, then valid_in held:
  - ready_out=0 until the cycle after that entry pops, and the next bundle enters then.
- Head has fu_sel=3'b101:
  - valid_out_fu=101; ready_in_fu=001 gives 100 next cycle.
  - Pop then loads the next head's 010, despite the 100 still pending.
- Queue holds 3 entries, flush_in pulsed one cycle with valid_in=1 and ready_in=1:
  - Next cycle count_out=0, valid_out=0, valid_out_fu=0, and no entry is pushed or popped.
- Assert reset=0 asynchronously mid-cycle with 2 entries:
  - Outputs go to reset values before the next clk edge.
  - After deassert, the first push appears at head one edge later.
